// File: rtl/inertial_pkg.sv
// Shared types and helpers for the inertial delay bank.
package inertial_pkg;

   typedef enum logic {IDLE, PEND} chan_state_t;

   localparam int CNT_W = 16;

   // A configured delay of zero still needs one edge to elapse.
   function automatic logic [31:0] clamp_delay(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage

// File: rtl/inertial_delay_chan.sv
// One inertial-delay inverter channel: schedules ~in onto out after a countdown,
// flagging reversions that happen while an event is in flight.
module inertial_delay_chan
   import inertial_pkg::*;
#(
   parameter int   DELAY_W  = 8,
   parameter logic OUT_INIT = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in,
   input  logic [DELAY_W-1:0] delay_cfg,
   input  logic               mode_dequeue,
   output logic               out,
   output logic               pending,
   output logic               unstable,
   output logic               killed,
   output logic [DELAY_W-1:0] cnt
);

   typedef struct packed {
      chan_state_t        state;
      logic [DELAY_W-1:0] cnt;
      logic               target;
      logic               rev;
      logic               out;
      logic               unstable;
      logic               killed;
   } chan_t;

   chan_t r, r_n;
   logic  ninv;

   assign ninv = ~in;

   always_ff @(posedge clk) begin
      if (reset)
         r <= '{state: IDLE, cnt: '0, target: OUT_INIT, rev: 1'b0,
                out: OUT_INIT, unstable: 1'b0, killed: 1'b0};
      else
         r <= r_n;
   end

   // rev marks "currently sitting reverted" so a held reversion counts once.
   always_comb begin
      r_n          = r;
      r_n.unstable = 1'b0;
      r_n.killed   = 1'b0;
      case (r.state)
         IDLE: begin
            if (ninv != r.out) begin
               r_n.state  = PEND;
               r_n.cnt    = DELAY_W'(clamp_delay(32'(delay_cfg)));
               r_n.target = ninv;
               r_n.rev    = 1'b0;
            end
         end
         PEND: begin
            if (ninv == r.out && !r.rev) begin
               r_n.unstable = 1'b1;
               r_n.rev      = 1'b1;
            end else if (ninv == r.target) begin
               r_n.rev = 1'b0;
            end
            // Instability outranks expiry, so a kill on the last edge cancels the fire.
            if (r_n.unstable && mode_dequeue) begin
               r_n.killed = 1'b1;
               r_n.state  = IDLE;
               r_n.cnt    = '0;
            end else if (r.cnt <= DELAY_W'(1)) begin
               r_n.out   = r.target;
               r_n.state = IDLE;
               r_n.cnt   = '0;
            end else begin
               r_n.cnt = r.cnt - DELAY_W'(1);
            end
         end
         default: r_n.state = IDLE;
      endcase
   end

   assign out      = r.out;
   assign pending  = (r.state == PEND);
   assign unstable = r.unstable;
   assign killed   = r.killed;
   assign cnt      = r.cnt;

endmodule

// File: rtl/inertial_delay_bank.sv
// Bank of NCH inertial-delay inverters with earliest-event reporting.
// INERTIAL_STATS_EN adds the saturating instability counter and event log.
module inertial_delay_bank
   import inertial_pkg::*;
#(
   parameter int   NCH      = 4,
   parameter int   DELAY_W  = 8,
   parameter logic OUT_INIT = 1'b0,
   localparam int  CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NCH-1:0]     in,
   input  logic [DELAY_W-1:0] delay_cfg,
   input  logic               mode_dequeue,
   output logic [NCH-1:0]     out,
   output logic [NCH-1:0]     pending,
   output logic [NCH-1:0]     unstable,
   output logic               next_valid,
   output logic [DELAY_W-1:0] next_time,
   output logic [CH_W-1:0]    next_ch,
   output logic [CNT_W-1:0]   unstable_count
);

   logic [NCH-1:0][DELAY_W-1:0] cnt;
   logic [NCH-1:0]              killed;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      inertial_delay_chan #(
         .DELAY_W  (DELAY_W),
         .OUT_INIT (OUT_INIT)
      ) u_chan (
         .clk          (clk),
         .reset        (reset),
         .in           (in[g]),
         .delay_cfg    (delay_cfg),
         .mode_dequeue (mode_dequeue),
         .out          (out[g]),
         .pending      (pending[g]),
         .unstable     (unstable[g]),
         .killed       (killed[g]),
         .cnt          (cnt[g])
      );
   end

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      next_valid = 1'b0;
      next_time  = '0;
      next_ch    = '0;
      for (int i = 0; i < NCH; i++) begin
         if (pending[i] && (!next_valid || cnt[i] < next_time)) begin
            next_valid = 1'b1;
            next_time  = cnt[i];
            next_ch    = CH_W'(i);
         end
      end
   end

`ifdef INERTIAL_STATS_EN
   localparam int PC_W  = CH_W + 1;
   localparam int SUM_W = CNT_W + 1;

   logic [PC_W-1:0]  n_unst;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] count_q;

   always_comb begin
      n_unst = '0;
      for (int i = 0; i < NCH; i++)
         n_unst = n_unst + PC_W'(unstable[i]);
   end

   assign sum = {1'b0, count_q} + SUM_W'(n_unst);

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   end

   always @(posedge clk) begin
      if (!reset)
         for (int i = 0; i < NCH; i++)
            if (unstable[i])
               $display("%0t inertial_delay_bank: instability ch=%0d %s",
                        $time, i, killed[i] ? "killed" : "kept");
   end

   assign unstable_count = count_q;
`else
   logic unused_killed;
   assign unused_killed  = ^killed;
   assign unstable_count = '0;
`endif

endmodule

// File: tb/tb_inertial_delay_bank.sv
// Directed bench for inertial_delay_bank with hand-computed expectations.
module tb_inertial_delay_bank;

   localparam int NCH = 4;
   localparam int DW  = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [NCH-1:0] in;
   logic [DW-1:0]  delay_cfg;
   logic           mode_dequeue;
   logic [NCH-1:0] out, pending, unstable;
   logic           next_valid;
   logic [DW-1:0]  next_time;
   logic [1:0]     next_ch;
   logic [15:0]    unstable_count;

   int total = 0;
   int bad   = 0;
   int ninst = 0;

   inertial_delay_bank #(.NCH(NCH), .DELAY_W(DW), .OUT_INIT(1'b0)) dut (
      .clk            (clk),
      .reset          (reset),
      .in             (in),
      .delay_cfg      (delay_cfg),
      .mode_dequeue   (mode_dequeue),
      .out            (out),
      .pending        (pending),
      .unstable       (unstable),
      .next_valid     (next_valid),
      .next_time      (next_time),
      .next_ch        (next_ch),
      .unstable_count (unstable_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] exp_count(input int n);
`ifdef INERTIAL_STATS_EN
      return (n > 65535) ? 32'hFFFF : 32'(n);
`else
      return (n > 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   initial begin
      reset = 1'b1; in = '0; delay_cfg = 8'd1; mode_dequeue = 1'b0;
      tick(2);
      chk("rst_out", out, 4'h0);
      chk("rst_pend", pending, 4'h0);
      chk("rst_unst", unstable, 4'h0);
      chk("rst_nv", next_valid, 1'b0);
      chk("rst_nt", next_time, 8'd0);
      chk("rst_nc", next_ch, 2'd0);
      chk("rst_cnt", unstable_count, 16'd0);
      reset = 1'b0;
      tick(1);
      chk("settle_pend", pending, 4'hF);
      tick(1);
      chk("settle_out", out, 4'hF);
      chk("settle_pend0", pending, 4'h0);

      // nominal delay of 5
      delay_cfg = 8'd5; in = 4'b0001;
      tick(1);
      chk("nom_pend", pending, 4'b0001);
      chk("nom_nv", next_valid, 1'b1);
      chk("nom_nt", next_time, 8'd5);
      chk("nom_nc", next_ch, 2'd0);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("nom_unst", unstable, 4'h0);
         chk("nom_hold", out, 4'hF);
      end
      chk("nom_nt1", next_time, 8'd1);
      tick(1);
      chk("nom_out", out, 4'b1110);
      chk("nom_pend0", pending, 4'h0);
      delay_cfg = 8'd1; in = 4'b0000;
      tick(2);
      chk("nom_restore", out, 4'hF);

      // dequeue kill
      mode_dequeue = 1'b1; delay_cfg = 8'd5; in = 4'b0010;
      tick(1);
      chk("deq_pend", pending, 4'b0010);
      tick(1);
      in = 4'b0000;
      tick(1);
      ninst++;
      chk("deq_unst", unstable, 4'b0010);
      chk("deq_pend0", pending, 4'h0);
      chk("deq_nv", next_valid, 1'b0);
      chk("deq_out", out, 4'hF);
      tick(1);
      chk("deq_unst_pulse", unstable, 4'h0);
      chk("deq_cnt", unstable_count, exp_count(ninst));
      tick(5);
      chk("deq_out_late", out, 4'hF);
      chk("deq_pend_late", pending, 4'h0);

      // warn only
      mode_dequeue = 1'b0; in = 4'b0010;
      tick(2);
      in = 4'b0000;
      tick(1);
      ninst++;
      chk("warn_unst", unstable, 4'b0010);
      chk("warn_pend", pending, 4'b0010);
      chk("warn_nt", next_time, 8'd3);
      tick(1);
      chk("warn_unst_once", unstable, 4'h0);
      tick(2);
      chk("warn_fire", out, 4'b1101);
      chk("warn_pend0", pending, 4'h0);
      tick(1);
      chk("warn_corr_pend", pending, 4'b0010);
      chk("warn_corr_nt", next_time, 8'd5);
      tick(4);
      chk("warn_corr_hold", out, 4'b1101);
      tick(1);
      chk("warn_corr_out", out, 4'hF);
      chk("warn_cnt", unstable_count, exp_count(ninst));

      // next-event tracking with a kill
      mode_dequeue = 1'b1; delay_cfg = 8'd8; in = 4'b0001;
      tick(3);
      in = 4'b0101;
      tick(1);
      chk("nxt_nc0", next_ch, 2'd0);
      chk("nxt_nt0", next_time, 8'd5);
      in = 4'b0100;
      tick(1);
      ninst++;
      chk("nxt_nc2", next_ch, 2'd2);
      chk("nxt_nt7", next_time, 8'd7);
      chk("nxt_unst", unstable, 4'b0001);
      chk("nxt_pend", pending, 4'b0100);
      tick(6);
      chk("nxt_nc_late", next_ch, 2'd2);
      chk("nxt_nt_late", next_time, 8'd1);
      chk("nxt_hold", out, 4'hF);
      tick(1);
      chk("nxt_fire", out, 4'b1011);
      chk("nxt_cnt", unstable_count, exp_count(ninst));
      delay_cfg = 8'd1; in = 4'b0000;
      tick(2);
      chk("nxt_restore", out, 4'hF);

      // delay_cfg = 0 behaves as 1
      delay_cfg = 8'd0; in = 4'b1000;
      tick(1);
      chk("d0_pend", pending, 4'b1000);
      chk("d0_nt", next_time, 8'd1);
      tick(1);
      chk("d0_out", out, 4'b0111);
      in = 4'b0000;
      tick(2);
      chk("d0_restore", out, 4'hF);

      // tie goes to lowest index
      delay_cfg = 8'd3; in = 4'b1010;
      tick(1);
      chk("tie_pend", pending, 4'b1010);
      chk("tie_nc", next_ch, 2'd1);
      chk("tie_nt", next_time, 8'd3);
      tick(3);
      chk("tie_out", out, 4'b0101);
      in = 4'b0000;
      tick(4);
      chk("tie_restore", out, 4'hF);

      // reversion on the expiry edge is cancelled
      mode_dequeue = 1'b1; delay_cfg = 8'd2; in = 4'b0001;
      tick(2);
      chk("exp_nt1", next_time, 8'd1);
      in = 4'b0000;
      tick(1);
      ninst++;
      chk("exp_unst", unstable, 4'b0001);
      chk("exp_pend", pending, 4'h0);
      chk("exp_out", out, 4'hF);
      tick(1);
      chk("exp_out_late", out, 4'hF);
      chk("exp_cnt", unstable_count, exp_count(ninst));

`ifdef INERTIAL_STATS_EN
      // four kills per two edges until the counter pins
      delay_cfg = 8'd5;
      for (int i = 0; i < 16385; i++) begin
         in = 4'hF;
         tick(1);
         in = 4'h0;
         tick(1);
      end
      ninst += 65540;
      tick(1);
      chk("sat_cnt", unstable_count, exp_count(ninst));
`endif

      // reset while pending
      mode_dequeue = 1'b0; delay_cfg = 8'd5; in = 4'b0100;
      tick(2);
      chk("mrst_pend", pending, 4'b0100);
      reset = 1'b1;
      tick(1);
      chk("mrst_out", out, 4'h0);
      chk("mrst_pend0", pending, 4'h0);
      chk("mrst_nv", next_valid, 1'b0);
      chk("mrst_unst", unstable, 4'h0);
      chk("mrst_cnt", unstable_count, 16'd0);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inertial_delay_bank.md
Name: inertial_delay_bank

Overview:
- Synchronous, parametrised bank of NCH delayed inverters.
- Gives Verilog-side co-simulation benches a cycle-accurate model of inertial-delay gates, shoelaced with prsim-driven nets.
- Detects unstable events: the input reverts while an output event is still pending.
- Optionally dequeues (kills) unstable events.
- Reports the next pending, non-killed event time across all channels.

Parameters:
- NCH, 4, number of independent channels.
- DELAY_W, 8, width of delay configuration and countdown.
- OUT_INIT, 0, reset value applied to every out bit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  NCH  channel inputs.
- delay_cfg  input  DELAY_W  gate delay in cycles, shared by all channels; 0 is treated as 1.
- mode_dequeue  input  1  1 = kill unstable events; 0 = warn only, event still fires.
- out  output  NCH  registered inverted, delayed copies of in.
- pending  output  NCH  channel has a live scheduled event.
- unstable  output  NCH  one-cycle pulse per instability.
- next_valid  output  1  at least one live event exists.
- next_time  output  DELAY_W  cycles remaining to the earliest live event.
- next_ch  output  $clog2(NCH) (min 1)  channel of the earliest live event.
- unstable_count  output  16  saturating total of instabilities.

Behaviour:
- Reset (synchronous, active-high) drives every channel to IDLE: out=OUT_INIT, pending=0, unstable=0, counters=0, unstable_count=0.
- Reset mid-pending discards every event; no output change results.
- Per-channel states are IDLE and PEND.
- IDLE: on an edge where ~in != out:
  - load cnt = max(delay_cfg, 1);
  - latch target = ~in;
  - go to PEND.
- PEND, sampled ~in == target (stable):
  - cnt decrements every edge;
  - on the edge where cnt goes 1->0, out <= target and the channel returns to IDLE.
- Latency: a change sampled at edge k appears on out after edge k+D. For D=1, out updates at edge k+1.
- PEND, sampled ~in == out (reverted, unstable):
  - unstable pulses high for exactly one cycle after that edge;
  - unstable_count increments (saturates at 16'hFFFF).
  - mode_dequeue=1: event killed, channel returns to IDLE, pending=0, out unchanged.
  - mode_dequeue=0: event kept, countdown continues, out takes target at expiry. IDLE then sees a mismatch and schedules a corrective event one edge later.
- A reversion sampled on the expiry edge counts as unstable. Instability evaluation takes priority over firing, so in dequeue mode the event is cancelled.
- A re-toggle after a kill is a fresh event: full delay, no instability.
- Only one event is pending per channel. Further toggles while in PEND with mode_dequeue=0 only re-raise unstable at each reversion.
- delay_cfg changes affect only events scheduled afterwards.
- next_time, next_ch and next_valid are combinational from registered state. They give the minimum cnt over channels with pending=1; ties go to the lowest index.
- Killed events never contribute to next_time. If no live events exist, next_valid=0 and next_time=0, next_ch=0.
- mode_dequeue is sampled every edge; a change applies to the next instability.

Optional Feature:
- INERTIAL_STATS_EN defined: the unstable_count register is implemented as above.
- When simulating, each instability also emits one $display with time, channel, and killed/kept status.
- Undefined: no counter logic, unstable_count tied to 16'd0, no display. All other behaviour is identical.

Decomposition:
- Package inertial_pkg: channel state enum (IDLE, PEND), a function clamping delay_cfg to at least 1, and the saturating-count width constant.
- Sub-module inertial_delay_chan: one channel's state, cnt, target, out, unstable and pending.
- The top instantiates NCH copies via generate, then performs the min/argmin reduction and the count.

Test Plan:
- Nominal delay: reset, delay_cfg=5, in[0] 0->1 at edge 10 -> out[0] goes 1->0 after edge 15, pending[0] high edges 10-14, unstable never pulses.
- Dequeue kill: mode_dequeue=1, delay_cfg=5, in[1] toggles at edge 20 and reverts at edge 22 -> unstable[1] pulses once, pending[1] drops, out[1] never changes, next_valid=0, unstable_count=1.
- Warn-only: same stimulus with mode_dequeue=0 -> out[1] changes after edge 25, a correction is scheduled at edge 26, out[1] is restored after edge 31, unstable_count=1.
- Next-event accuracy: delay_cfg=8, toggle ch0 at edge 40 and ch2 at edge 43, then kill ch0 at edge 44 (dequeue) -> next_ch=2, next_time=7 after edge 44, never reporting ch0.
- Boundaries: delay_cfg=0 behaves as 1; two channels with equal cnt report the lower index; reversion on the expiry edge is cancelled; reset asserted mid-PEND clears all and out=OUT_INIT.
- Saturation (INERTIAL_STATS_EN): force 65540 instabilities -> unstable_count holds 16'hFFFF; build without the macro -> unstable_count reads 0.
